// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM two-port arbiter: grant states, owner encoding and
// the default read data returned when the ack watchdog expires.
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_SPI,
    GRANT_USER,
    RECOVER
  } arb_state_t;

  typedef enum logic {
    OWNER_SPI,
    OWNER_USER
  } owner_t;

  localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

  function automatic owner_t grant_owner(input arb_state_t s);
    return (s == GRANT_SPI) ? OWNER_SPI : OWNER_USER;
  endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Registered arbiter between the SPI flash emulator (priority, read-only) and the
// user command parser; issues one single-beat SDRAM access at a time with a watchdog.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_critical,
  input  logic                  spi_req,
  input  logic [ADDR_WIDTH-2:0] spi_addr,
  output logic                  spi_ack,
  input  logic                  user_req,
  input  logic                  user_we,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  input  logic [DATA_WIDTH-1:0] user_wr_data,
  output logic                  user_ack,
  output logic                  user_idle,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  sd_enable,
  output logic                  sd_we,
  output logic [ADDR_WIDTH-1:0] sd_addr,
  output logic [DATA_WIDTH-1:0] sd_wr_data,
  input  logic [DATA_WIDTH-1:0] sd_rd_data,
  input  logic                  sd_ack,
  input  logic                  sd_idle,
  output logic                  sd_refresh_inhibit,
  output logic                  timeout
);

  // Counter is cleared on grant entry, so matching TIMEOUT-1 keeps sd_enable high
  // for exactly TIMEOUT cycles and pulses timeout TIMEOUT cycles after entry.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  arb_state_t state;
  logic [7:0] wd_cnt;

  assign user_idle = (state == IDLE) && sd_idle && !spi_critical;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      wd_cnt             <= '0;
      sd_enable          <= 1'b0;
      sd_we              <= 1'b0;
      sd_addr            <= '0;
      sd_wr_data         <= '0;
      rd_data            <= '0;
      spi_ack            <= 1'b0;
      user_ack           <= 1'b0;
      timeout            <= 1'b0;
      sd_refresh_inhibit <= 1'b0;
    end else begin
      spi_ack            <= 1'b0;
      user_ack           <= 1'b0;
      timeout            <= 1'b0;
      sd_refresh_inhibit <= spi_critical;
      unique case (state)
        IDLE: begin
          if (spi_req) begin
            state      <= GRANT_SPI;
            sd_addr    <= {spi_addr, 1'b0};
            sd_we      <= 1'b0;
            sd_wr_data <= '0;
            sd_enable  <= 1'b1;
            wd_cnt     <= '0;
          end else if (user_req && !spi_critical && sd_idle) begin
            state      <= GRANT_USER;
            sd_addr    <= user_addr;
            sd_we      <= user_we;
            sd_wr_data <= user_wr_data;
            sd_enable  <= 1'b1;
            wd_cnt     <= '0;
          end
        end
        GRANT_SPI, GRANT_USER: begin
          if (sd_ack || wd_cnt == WD_LAST) begin
            // A real ack wins over a watchdog expiry in the same cycle.
            if (sd_ack) begin
              if (!sd_we) rd_data <= sd_rd_data;
            end else begin
              rd_data <= ERR_DATA;
              timeout <= 1'b1;
            end
            if (grant_owner(state) == OWNER_SPI) spi_ack <= 1'b1;
            else user_ack <= 1'b1;
            sd_enable <= 1'b0;
            state     <= RECOVER;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: requesters and a memory-backed controller model
// are driven from the bench; expected commands and acks come from a reference model.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spi_critical, spi_req, spi_ack;
  logic [22:0] spi_addr;
  logic        user_req, user_we, user_ack, user_idle;
  logic [23:0] user_addr;
  logic [15:0] user_wr_data, rd_data;
  logic        sd_enable, sd_we;
  logic [23:0] sd_addr;
  logic [15:0] sd_wr_data, sd_rd_data;
  logic        ctrl_ack, spur_ack;
  wire         sd_ack = ctrl_ack | spur_ack;
  logic        sd_idle, sd_refresh_inhibit, timeout;

  sdram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .spi_critical(spi_critical), .spi_req(spi_req),
    .spi_addr(spi_addr), .spi_ack(spi_ack), .user_req(user_req), .user_we(user_we),
    .user_addr(user_addr), .user_wr_data(user_wr_data), .user_ack(user_ack),
    .user_idle(user_idle), .rd_data(rd_data), .sd_enable(sd_enable), .sd_we(sd_we),
    .sd_addr(sd_addr), .sd_wr_data(sd_wr_data), .sd_rd_data(sd_rd_data), .sd_ack(sd_ack),
    .sd_idle(sd_idle), .sd_refresh_inhibit(sd_refresh_inhibit), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [23:0] addr; bit we; logic [15:0] wd; } cmd_t;
  typedef struct { bit is_spi; logic [15:0] data; bit to; } resp_t;
  cmd_t  cmd_q[$];
  resp_t exp_q[$];
  int    rise_q[$];
  int    ack_q[$];

  // Reference model: word memory seen by requesters and last delivered read data.
  logic [15:0] ref_mem[logic [23:0]];
  logic [15:0] ctrl_mem[logic [23:0]];
  logic [15:0] last_rd;

  int ack_lat = 3;
  bit ack_drop = 0;
  int last_en = 0;

  function automatic logic [15:0] init_word(input logic [23:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void exp_user(input bit we, input logic [23:0] a, input logic [15:0] d);
    cmd_t c;
    resp_t r;
    c.addr = a; c.we = we; c.wd = d;
    cmd_q.push_back(c);
    if (we) ref_mem[a] = d;
    else last_rd = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    r.is_spi = 0; r.data = last_rd; r.to = 0;
    exp_q.push_back(r);
  endfunction

  function automatic void exp_spi(input logic [22:0] a, input bit to);
    cmd_t c;
    resp_t r;
    logic [23:0] w;
    w = {a, 1'b0};
    c.addr = w; c.we = 0; c.wd = 16'h0;
    cmd_q.push_back(c);
    if (to) last_rd = 16'hDEAD;
    else last_rd = ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    r.is_spi = 1; r.data = last_rd; r.to = to;
    exp_q.push_back(r);
  endfunction

  // Controller model: checks each new command, acks ack_lat cycles after enable rises.
  initial begin
    bit en_prev = 0;
    bit pending = 0;
    int left = 0;
    int en_cnt = 0;
    cmd_t e;
    ctrl_ack = 0;
    sd_rd_data = 16'h0;
    forever begin
      @(negedge clk);
      ctrl_ack = 0;
      if (sd_enable) begin
        if (!en_prev) begin
          en_cnt = 0;
          rise_q.push_back(cyc);
          if (cmd_q.size() == 0) chk("unexpected_grant", 1, 0);
          else begin
            e = cmd_q.pop_front();
            chk("cmd_addr", sd_addr, e.addr);
            chk("cmd_we", sd_we, e.we);
            chk("cmd_wdata", sd_wr_data, e.wd);
          end
          pending = !ack_drop;
          left = ack_lat - 1;
        end
        en_cnt++;
        if (pending) begin
          if (left == 0) begin
            if (sd_we) begin
              ctrl_mem[sd_addr] = sd_wr_data;
              sd_rd_data = 16'($urandom);
            end else begin
              sd_rd_data = ctrl_mem.exists(sd_addr) ? ctrl_mem[sd_addr] : init_word(sd_addr);
            end
            ctrl_ack = 1;
            pending = 0;
          end else left--;
        end
      end else if (en_prev) begin
        last_en = en_cnt;
      end
      en_prev = sd_enable;
    end
  end

  // Monitor: every ack pops the scoreboard.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (spi_ack || user_ack) begin
        ack_q.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("ack_exclusive", spi_ack & user_ack, 0);
          chk("ack_port_spi", spi_ack, e.is_spi);
          chk("ack_rd_data", rd_data, e.data);
          chk("ack_timeout", timeout, e.to);
          chk("ack_enable_low", sd_enable, 0);
        end
      end else if (timeout) begin
        chk("timeout_without_ack", timeout, 0);
      end
    end
  end

  task automatic wait_ack(input bit spi);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(spi ? spi_ack : user_ack) && n < 600);
    if (!(spi ? spi_ack : user_ack)) chk(spi ? "spi_ack_wait" : "user_ack_wait", 0, 1);
  endtask

  task automatic user_access(input bit we, input logic [23:0] a, input logic [15:0] d);
    user_we = we; user_addr = a; user_wr_data = d; user_req = 1;
    wait_ack(0);
    user_req = 0;
    @(negedge clk);
  endtask

  task automatic spi_access(input logic [22:0] a);
    spi_addr = a; spi_req = 1;
    wait_ack(1);
    spi_req = 0;
    @(negedge clk);
  endtask

  task automatic clear_times();
    rise_q.delete();
    ack_q.delete();
  endtask

  initial begin
    logic [23:0] ua;
    logic [15:0] ud;
    logic [22:0] sa;
    int k;
    reset_n = 0; spi_critical = 0; spi_req = 0; spi_addr = '0;
    user_req = 0; user_we = 0; user_addr = '0; user_wr_data = '0;
    spur_ack = 0; sd_idle = 1; last_rd = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_sd_enable", sd_enable, 0);
    chk("rst_outputs", {sd_we, sd_addr, sd_wr_data, rd_data}, 0);
    chk("rst_pulses", {spi_ack, user_ack, timeout, sd_refresh_inhibit}, 0);
    reset_n = 1;
    @(negedge clk);
    chk("idle_user_idle", user_idle, 1);

    // User write, 3-cycle controller latency, grant one cycle after request.
    clear_times();
    ack_lat = 3;
    exp_user(1, 24'h000010, 16'h1234);
    user_we = 1; user_addr = 24'h000010; user_wr_data = 16'h1234; user_req = 1;
    @(negedge clk);
    chk("grant_latency", sd_enable, 1);
    chk("busy_user_idle", user_idle, 0);
    wait_ack(0);
    user_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("write_enable_cycles", last_en, 3);

    // SPI and user in the same cycle: SPI first, user granted two cycles after spi_ack.
    clear_times();
    exp_spi(23'h000008, 0);
    exp_user(0, 24'h000010, 16'h0);
    fork
      spi_access(23'h000008);
      user_access(0, 24'h000010, 16'h0);
    join
    chk("tie_user_regrant", rise_q.size() >= 2 ? rise_q[1] - ack_q[0] : -1, 2);

    // spi_critical blocks user grants and raises refresh inhibit one cycle later.
    exp_user(0, 24'h000020, 16'h0);
    spi_critical = 1;
    user_we = 0; user_addr = 24'h000020; user_req = 1;
    #1 chk("inhibit_not_yet", sd_refresh_inhibit, 0);
    @(negedge clk);
    chk("inhibit_registered", sd_refresh_inhibit, 1);
    repeat (3) @(negedge clk);
    chk("crit_no_grant", sd_enable, 0);
    chk("crit_user_idle", user_idle, 0);
    spi_critical = 0;
    sd_idle = 0;
    repeat (2) @(negedge clk);
    chk("sd_busy_no_grant", sd_enable, 0);
    chk("sd_busy_user_idle", user_idle, 0);
    sd_idle = 1;
    @(negedge clk);
    chk("grant_after_release", sd_enable, 1);
    wait_ack(0);
    user_req = 0;
    @(negedge clk);

    // spi_critical rises mid user grant: the user access completes first.
    clear_times();
    ack_lat = 6;
    exp_user(1, 24'h000006, 16'hBEEF);
    exp_spi(23'h000003, 0);
    fork
      user_access(1, 24'h000006, 16'hBEEF);
      begin
        repeat (2) @(negedge clk);
        spi_critical = 1;
        spi_access(23'h000003);
      end
    join
    spi_critical = 0;
    chk("nopreempt_spi_grant", rise_q.size() >= 2 ? rise_q[1] - ack_q[0] : -1, 2);

    // Watchdog expiry on an SPI read.
    clear_times();
    ack_drop = 1;
    exp_spi(23'h000011, 1);
    spi_access(23'h000011);
    @(negedge clk);
    chk("timeout_enable_cycles", last_en, 255);
    chk("timeout_ack_delay", ack_q.size() > 0 ? ack_q[0] - rise_q[0] : -1, 255);

    // Reset in the middle of an SPI grant.
    cmd_q.push_back('{addr: 24'h00000A, we: 1'b0, wd: 16'h0});
    spi_addr = 23'h000005; spi_req = 1;
    repeat (4) @(negedge clk);
    #2 reset_n = 0;
    #1 chk("rst_mid_enable", sd_enable, 0);
    chk("rst_mid_outputs", {spi_ack, user_ack, timeout, sd_addr, rd_data}, 0);
    @(negedge clk);
    spi_req = 0;
    ack_drop = 0;
    last_rd = 16'h0;
    @(negedge clk);
    reset_n = 1;
    repeat (4) @(negedge clk);
    chk("rst_release_idle", user_idle, 1);
    chk("rst_release_no_grant", sd_enable, 0);

    // Randomized mix with spurious acks between transactions.
    for (int i = 0; i < 40; i++) begin
      ack_lat = $urandom_range(1, 5);
      k = $urandom_range(0, 3);
      ua = 24'({$urandom_range(0, 15), 1'b0});
      ud = 16'($urandom);
      sa = 23'($urandom_range(0, 15));
      case (k)
        0: begin exp_user(1, ua, ud); user_access(1, ua, ud); end
        1: begin exp_user(0, ua, ud); user_access(0, ua, ud); end
        2: begin exp_spi(sa, 0); spi_access(sa); end
        default: begin
          exp_spi(sa, 0);
          exp_user(0, ua, ud);
          fork
            spi_access(sa);
            user_access(0, ua, ud);
          join
        end
      endcase
      if ($urandom_range(0, 2) == 0) begin
        spur_ack = 1;
        repeat (2) @(negedge clk);
        spur_ack = 0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("commands_drained", cmd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
